// File: rtl/riscv_store_unit_pkg.sv
// Shared store-path definitions: width selector, store FSM states, lane masks.
package riscv_store_unit_pkg;

    // Width selector shared with the load path; the _SEXT flavours only matter for loads.
    typedef enum logic [2:0] {
        MASK_X      = 3'd0,
        MASK_B      = 3'd1,
        MASK_H      = 3'd2,
        MASK_B_SEXT = 3'd3,
        MASK_H_SEXT = 3'd4
    } mask_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } store_state_e;

    // Lane masks, positioned at lane 0 and shifted into place by the merge.
    localparam logic [31:0] RG_SB_MASK = 32'h0000_00FF;
    localparam logic [31:0] RG_SH_MASK = 32'h0000_FFFF;

    // A request is refused when its width does not fit its alignment, or the selector is undefined.
    function automatic logic store_rejected(mask_sel_e sel, logic [1:0] lane);
        case (sel)
            MASK_X:              return lane != 2'b00;
            MASK_B, MASK_B_SEXT: return 1'b0;
            MASK_H, MASK_H_SEXT: return lane[0];
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/riscv_store_unit_merge.sv
// Combinational byte/half insertion into a previously read RAM word.
module riscv_store_merge
    import riscv_store_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  lane,
    input  logic        is_half,
    output logic [31:0] merged
);
    logic [31:0] mask;
    logic [31:0] ins;
    logic [4:0]  sh;

    // Position the low bits of the store data at the addressed lane; keep everything else.
    always_comb begin
        sh   = is_half ? {lane[1], 4'b0000} : {lane, 3'b000};
        mask = (is_half ? RG_SH_MASK : RG_SB_MASK) << sh;
        ins  = new_data << sh;
        merged = (old_word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/riscv_store_unit.sv
// Store unit for a word-wide RAM without byte enables: SW writes directly,
// SB/SH do read-modify-write. All RAM strobes and status pulses are flops.
module riscv_store_unit
    import riscv_store_unit_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [WORD_LENGTH-1:0] req_data,
    input  mask_sel_e              req_mask_sel,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic                   ram_rd_en,
    input  logic [WORD_LENGTH-1:0] ram_rd_data,
    output logic                   ram_wr_en,
    output logic [WORD_LENGTH-1:0] ram_wr_data,
    output logic                   done,
    output logic                   misaligned
);
    store_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [WORD_LENGTH-1:0] wr_data_q, wr_data_d;
    mask_sel_e              mask_sel_q, mask_sel_d;
    logic [1:0]             lane_q, lane_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   done_q, done_d;
    logic                   mis_q, mis_d;
    logic                   is_half;
    logic [WORD_LENGTH-1:0] merged;

    assign is_half = (mask_sel_q == MASK_H) || (mask_sel_q == MASK_H_SEXT);

    riscv_store_merge u_merge (
        .old_word (ram_rd_data),
        .new_data (data_q),
        .lane     (lane_q),
        .is_half  (is_half),
        .merged   (merged)
    );

    // Next-state and registered-strobe decode; strobes are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        data_d     = data_q;
        wr_data_d  = wr_data_q;
        mask_sel_d = mask_sel_q;
        lane_d     = lane_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ram_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    data_d     = req_data;
                    mask_sel_d = req_mask_sel;
                    lane_d     = req_addr[1:0];
                    if (store_rejected(req_mask_sel, req_addr[1:0])) begin
                        state_d = ST_ERR;
                        mis_d   = 1'b1;
                    end else if (req_mask_sel == MASK_X) begin
                        state_d   = ST_WRITE;
                        wr_data_d = req_data;
                        wr_en_d   = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        rd_en_d = 1'b1;
                    end
                end
            end
            ST_READ:  state_d = ST_MERGE;
            ST_MERGE: begin
                // ram_rd_data is valid now, one cycle after the read strobe.
                wr_data_d = merged;
                state_d   = ST_WRITE;
                wr_en_d   = 1'b1;
                done_d    = 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any in-flight store before it writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ram_addr_q <= '0;
            data_q     <= '0;
            wr_data_q  <= '0;
            mask_sel_q <= MASK_X;
            lane_q     <= 2'b00;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            data_q     <= data_d;
            wr_data_q  <= wr_data_d;
            mask_sel_q <= mask_sel_d;
            lane_q     <= lane_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign ram_addr    = ram_addr_q;
    assign ram_rd_en   = rd_en_q;
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_data = wr_data_q;
    assign done        = done_q;
    assign misaligned  = mis_q;

endmodule
